// File: rtl/counter4_checker_pkg.sv
// Shared types and constants for the 4-bit triangle-sequence checker.
package counter4_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    TRACK = 2'd2
  } state_e;

  localparam logic [3:0] CNT_MAX      = 4'hF;
  localparam logic [3:0] CNT_MIN      = 4'h0;
  localparam int         LOCK_LEN_DEF = 4;

endpackage

// File: rtl/counter4_checker_if.sv
// Sample/result bus between a 4-bit up/down counter source and its checker.
// master = source side (drives in), slave = checker side.
interface counter4_checker_if #(
  parameter int ERR_W = 8
);
  logic [3:0]       in;
  logic             locked;
  logic             dir;
  logic             err;
  logic             period_done;
  logic [ERR_W-1:0] err_count;

  modport master (output in, input  locked, dir, err, period_done, err_count);
  modport slave  (input  in, output locked, dir, err, period_done, err_count);
endinterface

// File: rtl/counter4_checker_next.sv
// Expected-next value of the triangle sequence: one step from prev in dir,
// with a one-sample dwell at each endpoint where the direction flips.
module counter4_next
  import counter4_chk_pkg::*;
(
  input  logic [3:0] prev_i,
  input  logic       dir_i,
  output logic [3:0] exp_o,
  output logic       dir_next_o
);

  // Endpoints repeat once and reverse; otherwise step by one.
  always_comb begin
    exp_o      = prev_i;
    dir_next_o = dir_i;
    if (dir_i) begin
      if (prev_i == CNT_MAX) dir_next_o = 1'b0;
      else                   exp_o      = prev_i + 4'd1;
    end else begin
      if (prev_i == CNT_MIN) dir_next_o = 1'b1;
      else                   exp_o      = prev_i - 4'd1;
    end
  end

endmodule

// File: rtl/counter4_checker.sv
// Triangle-sequence checker: acquires lock on 0..15,15..0, then tracks it,
// flagging mismatches and completed periods. All outputs registered.
// Optional: COUNTER4_CHK_ERRCNT_EN builds the saturating error counter;
// without it err_count is tied to zero.
module counter4_checker
  import counter4_chk_pkg::*;
#(
  parameter int LOCK_LEN = LOCK_LEN_DEF,
  parameter int ERR_W    = 8
)(
  input  logic               clock,
  input  logic               reset,
  counter4_checker_if.slave  bus
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_LEN);

  state_e     state_q, state_d;
  logic [3:0] prev_q;
  logic       prev_valid_q, prev_valid_d;
  logic       dir_q, dir_d;
  logic [3:0] match_cnt_q, match_cnt_d;
  logic       locked_q, locked_d;
  logic       err_q, err_d;
  logic       pd_q, pd_d;

  logic [3:0] exp_val;
  logic       dir_nx;
  logic       hit, infer_up, infer_dn;

  counter4_next u_next (
    .prev_i     (prev_q),
    .dir_i      (dir_q),
    .exp_o      (exp_val),
    .dir_next_o (dir_nx)
  );

  assign hit      = (bus.in == exp_val);
  // Direction guesses from a bare pair; 15->0 and 0->15 imply neither.
  assign infer_up = ((prev_q != CNT_MAX) && (bus.in == prev_q + 4'd1)) ||
                    ((prev_q == CNT_MIN) && (bus.in == CNT_MIN));
  assign infer_dn = ((prev_q != CNT_MIN) && (bus.in == prev_q - 4'd1)) ||
                    ((prev_q == CNT_MAX) && (bus.in == CNT_MAX));

  // Next-state: acquire by counting consistent transitions, then track.
  always_comb begin
    state_d      = state_q;
    prev_valid_d = prev_valid_q;
    dir_d        = dir_q;
    match_cnt_d  = match_cnt_q;
    err_d        = 1'b0;
    pd_d         = 1'b0;
    unique case (state_q)
      IDLE: begin
        prev_valid_d = 1'b1;
        state_d      = ACQ;
      end
      ACQ: begin
        if (!prev_valid_q) begin
          state_d = IDLE;
        end else begin
          if (match_cnt_q == 4'd0) begin
            if (infer_up || infer_dn) begin
              match_cnt_d = 4'd1;
              dir_d       = infer_up;
            end
          end else if (hit) begin
            match_cnt_d = (match_cnt_q == 4'hF) ? 4'hF : match_cnt_q + 4'd1;
            dir_d       = dir_nx;
          end else begin
            match_cnt_d = 4'd0;
          end
          if (match_cnt_d >= LOCK_N) state_d = TRACK;
        end
      end
      TRACK: begin
        if (hit) begin
          dir_d = dir_nx;
          pd_d  = (prev_q == CNT_MIN) && (bus.in == CNT_MIN);
        end else begin
          err_d       = 1'b1;
          match_cnt_d = 4'd0;
          state_d     = ACQ;
        end
      end
      default: state_d = IDLE;
    endcase
    locked_d = (state_d == TRACK);
  end

  // State and output registers; reset wins over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      prev_q       <= 4'd0;
      prev_valid_q <= 1'b0;
      dir_q        <= 1'b1;
      match_cnt_q  <= 4'd0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      pd_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= bus.in;
      prev_valid_q <= prev_valid_d;
      dir_q        <= dir_d;
      match_cnt_q  <= match_cnt_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      pd_q         <= pd_d;
    end
  end

`ifdef COUNTER4_CHK_ERRCNT_EN
  logic [ERR_W-1:0] err_count_q;

  // Saturating mismatch count; only TRACK misses raise err_d.
  always_ff @(posedge clock) begin
    if (reset)                             err_count_q <= '0;
    else if (err_d && (err_count_q != '1)) err_count_q <= err_count_q + ERR_W'(1);
  end

  assign bus.err_count = err_count_q;
`else
  assign bus.err_count = {ERR_W{1'b0}};
`endif

  assign bus.locked      = locked_q;
  assign bus.dir         = dir_q;
  assign bus.err         = err_q;
  assign bus.period_done = pd_q;

endmodule

// File: tb/tb_counter4_checker.sv
// Scoreboard bench for counter4_checker: a phase-based model of the
// 32-step triangle predicts each cycle's outputs into a queue; a monitor
// pops and compares one entry per clock.
module tb_counter4_checker;

  localparam int LOCK_LEN = 4;
  localparam int ERR_W    = 2;
  localparam int EC_MAX   = (1 << ERR_W) - 1;
`ifdef COUNTER4_CHK_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    logic             locked;
    logic             dir;
    logic             err;
    logic             pd;
    logic [ERR_W-1:0] ec;
    string            tag;
  } exp_t;

  logic clock;
  logic reset;
  counter4_checker_if #(.ERR_W(ERR_W)) bus ();

  counter4_checker #(.LOCK_LEN(LOCK_LEN), .ERR_W(ERR_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: position within the 32-sample period.
  bit   m_have = 0;
  int   m_run  = 0;
  int   m_ph   = 0;
  bit   m_lock = 0;
  bit   m_dir  = 1;
  int   m_ec   = 0;
  int   m_prev = 0;
  int   src_ph = 0;

  function automatic int tri_val(input int p);
    int q;
    q = p % 32;
    return (q < 16) ? q : 31 - q;
  endfunction

  task automatic step(input bit r, input int x, input string tag);
    exp_t e;
    bit   m_err, m_pd, found;
    @(negedge clock);
    reset  = r;
    bus.in = 4'(x);
    m_err = 0;
    m_pd  = 0;
    if (r) begin
      m_have = 0; m_run = 0; m_lock = 0; m_dir = 1; m_ec = 0;
    end else if (!m_have) begin
      m_have = 1;
    end else if (m_run == 0) begin
      found = 0;
      for (int q = 0; q < 32; q++) begin
        if (!found && tri_val(q) == m_prev && tri_val(q + 1) == x) begin
          found = 1;
          m_ph  = (q + 1) % 32;
          m_run = 1;
          m_dir = (m_ph <= 15);
        end
      end
    end else if (tri_val(m_ph + 1) == x) begin
      m_ph = (m_ph + 1) % 32;
      if (m_run < 15) m_run++;
      m_dir = (m_ph <= 15);
      if (m_lock && m_ph == 0) m_pd = 1;
    end else begin
      if (m_lock) begin
        m_err  = 1;
        m_lock = 0;
        if (m_ec < EC_MAX) m_ec++;
      end
      m_run = 0;
    end
    if (m_run >= LOCK_LEN) m_lock = 1;
    if (!r) m_prev = x;
    e.locked = m_lock;
    e.dir    = m_dir;
    e.err    = m_err;
    e.pd     = m_pd;
    e.ec     = CNT_EN ? ERR_W'(m_ec) : '0;
    e.tag    = tag;
    sb.push_back(e);
  endtask

  task automatic run_seq(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step(0, tri_val(src_ph), tag);
      src_ph++;
    end
  endtask

  // Monitor: one expected entry per clock, compared after the edge settles.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (bus.locked !== e.locked || bus.dir !== e.dir || bus.err !== e.err ||
            bus.period_done !== e.pd || bus.err_count !== e.ec) begin
          miscompares++;
          $display("FAIL %s: got locked=%0b dir=%0b err=%0b pd=%0b cnt=%0d, want locked=%0b dir=%0b err=%0b pd=%0b cnt=%0d",
                   e.tag, bus.locked, bus.dir, bus.err, bus.period_done, bus.err_count,
                   e.locked, e.dir, e.err, e.pd, e.ec);
        end
      end
    end
  end

  initial begin
    int p;
    int wait_cyc;
    reset  = 1'b1;
    bus.in = 4'd0;

    step(1, 0, "reset");
    step(1, 0, "reset");
    src_ph = 0;
    run_seq(64, "clean");

    step(1, 0, "reset");
    src_ph = 22;
    run_seq(40, "mid_desc");

    step(1, 0, "reset");
    src_ph = 0;
    run_seq(8, "pre_glitch");
    step(0, 3, "glitch");
    src_ph = 4;
    run_seq(10, "relock");

    src_ph = 10;
    run_seq(4, "to_top");
    step(0, 14, "top_nodwell");
    step(0, 13, "after_top");
    src_ph = 19;
    run_seq(10, "resume");

    for (int k = 0; k < 5; k++) begin
      run_seq(8, "sat_track");
      step(0, tri_val(src_ph) ^ 8, "sat_glitch");
    end
    run_seq(8, "sat_tail");

    step(1, 0, "reset");
    src_ph = 0;
    run_seq(12, "to_11");
    step(1, 12, "rst_mid");
    src_ph = 13;
    run_seq(12, "post_rst");

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        step(1, int'($urandom_range(0, 15)), "rand_rst");
      end else begin
        p = int'($urandom_range(0, 99));
        if (p < 5) begin
          step(0, int'($urandom_range(0, 15)), "rand_junk");
        end else begin
          if (p < 7) src_ph = int'($urandom_range(0, 31));
          run_seq(1, "rand_seq");
        end
      end
    end

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 10) begin
      @(posedge clock);
      wait_cyc++;
    end
    #2;
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d entries pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
